// File: rtl/acc_pkg.sv
// Shared constants, field positions and helpers for the accumulator /
// system-register write arbiter.
package acc_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ACC_NUM     = 16;
    localparam int unsigned SYS_NUM     = 8;
    localparam int unsigned ACC_IDX_W   = 4;
    localparam int unsigned SYS_IDX_W   = 3;

    // Sysreg index that holds the hardware conflict counter; writes to it are discarded.
    localparam logic [2:0]  CONF_CNT_IDX = 3'd7;
    localparam logic [31:0] CONF_CNT_MAX = 32'hFFFF_FFFF;

    // Write-enable vector layout: {valid, index}
    localparam int unsigned ACC_VLD_BIT = 4;
    localparam int unsigned SYS_VLD_BIT = 3;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [ACC_IDX_W-1:0] acc_idx_t;
    typedef logic [SYS_IDX_W-1:0] sys_idx_t;

    // Saturating increment used by the conflict counter.
    function automatic data_t sat_inc(input data_t val);
        data_t res;
        if (val == CONF_CNT_MAX) begin
            res = val;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

    // Index field of an accumulator write-enable vector.
    function automatic acc_idx_t acc_wen_idx(input logic [ACC_VLD_BIT:0] vec);
        return vec[ACC_IDX_W-1:0];
    endfunction

    // Index field of a sysreg write-enable vector.
    function automatic sys_idx_t sys_wen_idx(input logic [SYS_VLD_BIT:0] vec);
        return vec[SYS_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/wr_arb2.sv
// Two-requester write arbiter: requests to different indices are both granted,
// same-index requests are resolved round-robin with a one-bit pointer that
// flips to the loser on every conflict.
module wr_arb2 #(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_a_i,
    input  logic [IDX_W-1:0] idx_a_i,
    input  logic             valid_b_i,
    input  logic [IDX_W-1:0] idx_b_i,
    output logic             grant_a,
    output logic             grant_b,
    output logic             conflict
);

    // pri_q: 0 = A wins the next conflict, 1 = B wins it
    logic pri_q;
    logic pri_d;
    logic same_idx_s;

    assign same_idx_s = valid_a_i & valid_b_i & (idx_a_i == idx_b_i);

    // Grant decode; nothing is granted while reset is held.
    always_comb begin
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        conflict = 1'b0;
        if (rst_i) begin
            grant_a  = 1'b0;
            grant_b  = 1'b0;
            conflict = 1'b0;
        end else if (same_idx_s) begin
            conflict = 1'b1;
            grant_a  = ~pri_q;
            grant_b  = pri_q;
        end else begin
            conflict = 1'b0;
            grant_a  = valid_a_i;
            grant_b  = valid_b_i;
        end
    end

    // Pointer moves to the loser only on a conflict cycle.
    always_comb begin
        pri_d = pri_q;
        if (conflict) begin
            pri_d = ~pri_q;
        end else begin
            pri_d = pri_q;
        end
    end

    // Pointer flop with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule

// File: rtl/acc_sysreg_arb1.sv
// Accumulator and system-register file with two write ports per bank.
// Same-index collisions are arbitrated round-robin; sysreg07 counts
// conflict cycles and saturates.
module acc_sysreg_arb1
    import acc_pkg::*;
(
    input  logic        clk_i_asa,
    input  logic        rst_i_asa,
    input  logic [4:0]  acc_wen_vctr_a_i_asa,
    input  logic [31:0] acc_wdata_a_i_asa,
    input  logic [4:0]  acc_wen_vctr_b_i_asa,
    input  logic [31:0] acc_wdata_b_i_asa,
    output logic        acc_ack_a_o_asa,
    output logic        acc_ack_b_o_asa,
    input  logic [3:0]  sys_wen_vctr_a_i_asa,
    input  logic [31:0] sys_wdata_a_i_asa,
    input  logic [3:0]  sys_wen_vctr_b_i_asa,
    input  logic [31:0] sys_wdata_b_i_asa,
    output logic        sys_ack_a_o_asa,
    output logic        sys_ack_b_o_asa,
    output logic [31:0] acc00_o_asa,
    output logic [31:0] acc01_o_asa,
    output logic [31:0] acc02_o_asa,
    output logic [31:0] acc03_o_asa,
    output logic [31:0] acc04_o_asa,
    output logic [31:0] acc05_o_asa,
    output logic [31:0] acc06_o_asa,
    output logic [31:0] acc07_o_asa,
    output logic [31:0] acc08_o_asa,
    output logic [31:0] acc09_o_asa,
    output logic [31:0] acc10_o_asa,
    output logic [31:0] acc11_o_asa,
    output logic [31:0] acc12_o_asa,
    output logic [31:0] acc13_o_asa,
    output logic [31:0] acc14_o_asa,
    output logic [31:0] acc15_o_asa,
    output logic [31:0] sysreg00_o_asa,
    output logic [31:0] sysreg01_o_asa,
    output logic [31:0] sysreg02_o_asa,
    output logic [31:0] sysreg03_o_asa,
    output logic [31:0] sysreg04_o_asa,
    output logic [31:0] sysreg05_o_asa,
    output logic [31:0] sysreg06_o_asa,
    output logic [31:0] sysreg07_o_asa
);

    localparam int unsigned SYS_RW_NUM = int'(CONF_CNT_IDX);  // writable sysregs 0..6

    logic     acc_vld_a_s, acc_vld_b_s;
    acc_idx_t acc_idx_a_s, acc_idx_b_s;
    logic     sys_vld_a_s, sys_vld_b_s;
    sys_idx_t sys_idx_a_s, sys_idx_b_s;

    logic acc_gnt_a_s, acc_gnt_b_s, acc_conf_s;
    logic sys_gnt_a_s, sys_gnt_b_s, sys_conf_s;

    logic [ACC_NUM-1:0][DATA_W-1:0]    acc_q, acc_d;
    logic [SYS_RW_NUM-1:0][DATA_W-1:0] sys_q, sys_d;
    data_t                             conf_cnt_q, conf_cnt_d;

    assign acc_vld_a_s = acc_wen_vctr_a_i_asa[ACC_VLD_BIT];
    assign acc_vld_b_s = acc_wen_vctr_b_i_asa[ACC_VLD_BIT];
    assign acc_idx_a_s = acc_wen_idx(acc_wen_vctr_a_i_asa);
    assign acc_idx_b_s = acc_wen_idx(acc_wen_vctr_b_i_asa);
    assign sys_vld_a_s = sys_wen_vctr_a_i_asa[SYS_VLD_BIT];
    assign sys_vld_b_s = sys_wen_vctr_b_i_asa[SYS_VLD_BIT];
    assign sys_idx_a_s = sys_wen_idx(sys_wen_vctr_a_i_asa);
    assign sys_idx_b_s = sys_wen_idx(sys_wen_vctr_b_i_asa);

    wr_arb2 #(.IDX_W(ACC_IDX_W)) u_acc_arb (
        .clk_i     (clk_i_asa),
        .rst_i     (rst_i_asa),
        .valid_a_i (acc_vld_a_s),
        .idx_a_i   (acc_idx_a_s),
        .valid_b_i (acc_vld_b_s),
        .idx_b_i   (acc_idx_b_s),
        .grant_a   (acc_gnt_a_s),
        .grant_b   (acc_gnt_b_s),
        .conflict  (acc_conf_s)
    );

    wr_arb2 #(.IDX_W(SYS_IDX_W)) u_sys_arb (
        .clk_i     (clk_i_asa),
        .rst_i     (rst_i_asa),
        .valid_a_i (sys_vld_a_s),
        .idx_a_i   (sys_idx_a_s),
        .valid_b_i (sys_vld_b_s),
        .idx_b_i   (sys_idx_b_s),
        .grant_a   (sys_gnt_a_s),
        .grant_b   (sys_gnt_b_s),
        .conflict  (sys_conf_s)
    );

    // Acks follow the grants in the same cycle so the pipes can release their requests.
    assign acc_ack_a_o_asa = acc_gnt_a_s;
    assign acc_ack_b_o_asa = acc_gnt_b_s;
    assign sys_ack_a_o_asa = sys_gnt_a_s;
    assign sys_ack_b_o_asa = sys_gnt_b_s;

    // Accumulator write decode; both grants never target the same entry.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < ACC_NUM; i++) begin
            if (acc_gnt_a_s && (acc_idx_a_s == ACC_IDX_W'(i))) begin
                acc_d[i] = acc_wdata_a_i_asa;
            end else if (acc_gnt_b_s && (acc_idx_b_s == ACC_IDX_W'(i))) begin
                acc_d[i] = acc_wdata_b_i_asa;
            end else begin
                acc_d[i] = acc_q[i];
            end
        end
    end

    // Sysreg write decode; the counter slot is outside this array so its writes fall away.
    always_comb begin
        sys_d = sys_q;
        for (int i = 0; i < SYS_RW_NUM; i++) begin
            if (sys_gnt_a_s && (sys_idx_a_s == SYS_IDX_W'(i))) begin
                sys_d[i] = sys_wdata_a_i_asa;
            end else if (sys_gnt_b_s && (sys_idx_b_s == SYS_IDX_W'(i))) begin
                sys_d[i] = sys_wdata_b_i_asa;
            end else begin
                sys_d[i] = sys_q[i];
            end
        end
    end

    // Conflict counter: one count per conflict cycle, whichever bank(s) collided.
    always_comb begin
        conf_cnt_d = conf_cnt_q;
        if (acc_conf_s || sys_conf_s) begin
            conf_cnt_d = sat_inc(conf_cnt_q);
        end else begin
            conf_cnt_d = conf_cnt_q;
        end
    end

    // Register storage with synchronous reset.
    always_ff @(posedge clk_i_asa) begin
        if (rst_i_asa) begin
            acc_q      <= '0;
            sys_q      <= '0;
            conf_cnt_q <= 32'd0;
        end else begin
            acc_q      <= acc_d;
            sys_q      <= sys_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign acc00_o_asa    = acc_q[0];
    assign acc01_o_asa    = acc_q[1];
    assign acc02_o_asa    = acc_q[2];
    assign acc03_o_asa    = acc_q[3];
    assign acc04_o_asa    = acc_q[4];
    assign acc05_o_asa    = acc_q[5];
    assign acc06_o_asa    = acc_q[6];
    assign acc07_o_asa    = acc_q[7];
    assign acc08_o_asa    = acc_q[8];
    assign acc09_o_asa    = acc_q[9];
    assign acc10_o_asa    = acc_q[10];
    assign acc11_o_asa    = acc_q[11];
    assign acc12_o_asa    = acc_q[12];
    assign acc13_o_asa    = acc_q[13];
    assign acc14_o_asa    = acc_q[14];
    assign acc15_o_asa    = acc_q[15];
    assign sysreg00_o_asa = sys_q[0];
    assign sysreg01_o_asa = sys_q[1];
    assign sysreg02_o_asa = sys_q[2];
    assign sysreg03_o_asa = sys_q[3];
    assign sysreg04_o_asa = sys_q[4];
    assign sysreg05_o_asa = sys_q[5];
    assign sysreg06_o_asa = sys_q[6];
    assign sysreg07_o_asa = conf_cnt_q;

endmodule

// File: tb/tb_acc_sysreg_arb1.sv
// Scoreboard bench for acc_sysreg_arb1: each driven cycle pushes the expected
// register image, which is popped and compared after the clock edge.
module tb_acc_sysreg_arb1;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  acc_wen_a, acc_wen_b;
    logic [31:0] acc_wd_a, acc_wd_b;
    logic [3:0]  sys_wen_a, sys_wen_b;
    logic [31:0] sys_wd_a, sys_wd_b;
    logic        acc_ack_a, acc_ack_b, sys_ack_a, sys_ack_b;
    logic [31:0] acc_o [0:15];
    logic [31:0] sys_o [0:7];

    typedef struct packed {
        logic [15:0][31:0] acc;
        logic [6:0][31:0]  sys;
        logic [31:0]       cnt;
    } snap_t;

    snap_t exp_q[$];

    // reference model state
    logic [15:0][31:0] m_acc;
    logic [6:0][31:0]  m_sys;
    logic [31:0]       m_cnt;
    logic              m_apri, m_spri;
    logic              m_ga, m_gb, m_sga, m_sgb;
    // DUT acks sampled in the last step
    logic              d_ga, d_gb, d_sga, d_sgb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    acc_sysreg_arb1 dut (
        .clk_i_asa            (clk),
        .rst_i_asa            (rst),
        .acc_wen_vctr_a_i_asa (acc_wen_a),
        .acc_wdata_a_i_asa    (acc_wd_a),
        .acc_wen_vctr_b_i_asa (acc_wen_b),
        .acc_wdata_b_i_asa    (acc_wd_b),
        .acc_ack_a_o_asa      (acc_ack_a),
        .acc_ack_b_o_asa      (acc_ack_b),
        .sys_wen_vctr_a_i_asa (sys_wen_a),
        .sys_wdata_a_i_asa    (sys_wd_a),
        .sys_wen_vctr_b_i_asa (sys_wen_b),
        .sys_wdata_b_i_asa    (sys_wd_b),
        .sys_ack_a_o_asa      (sys_ack_a),
        .sys_ack_b_o_asa      (sys_ack_b),
        .acc00_o_asa (acc_o[0]),  .acc01_o_asa (acc_o[1]),
        .acc02_o_asa (acc_o[2]),  .acc03_o_asa (acc_o[3]),
        .acc04_o_asa (acc_o[4]),  .acc05_o_asa (acc_o[5]),
        .acc06_o_asa (acc_o[6]),  .acc07_o_asa (acc_o[7]),
        .acc08_o_asa (acc_o[8]),  .acc09_o_asa (acc_o[9]),
        .acc10_o_asa (acc_o[10]), .acc11_o_asa (acc_o[11]),
        .acc12_o_asa (acc_o[12]), .acc13_o_asa (acc_o[13]),
        .acc14_o_asa (acc_o[14]), .acc15_o_asa (acc_o[15]),
        .sysreg00_o_asa (sys_o[0]), .sysreg01_o_asa (sys_o[1]),
        .sysreg02_o_asa (sys_o[2]), .sysreg03_o_asa (sys_o[3]),
        .sysreg04_o_asa (sys_o[4]), .sysreg05_o_asa (sys_o[5]),
        .sysreg06_o_asa (sys_o[6]), .sysreg07_o_asa (sys_o[7])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle (called at a falling edge), check acks, push the expected
    // image, then compare it against the registers after the rising edge.
    task automatic step(input logic r,
                        input logic av, input logic [3:0] ai, input logic [31:0] ad,
                        input logic bv, input logic [3:0] bi, input logic [31:0] bd,
                        input logic sav, input logic [2:0] sai, input logic [31:0] sad,
                        input logic sbv, input logic [2:0] sbi, input logic [31:0] sbd);
        snap_t s;
        logic  ca, sca;
        rst       = r;
        acc_wen_a = {av, ai};   acc_wd_a = ad;
        acc_wen_b = {bv, bi};   acc_wd_b = bd;
        sys_wen_a = {sav, sai}; sys_wd_a = sad;
        sys_wen_b = {sbv, sbi}; sys_wd_b = sbd;
        #1;
        ca  = av && bv && (ai == bi);
        sca = sav && sbv && (sai == sbi);
        if (r) begin
            m_ga = 1'b0; m_gb = 1'b0; m_sga = 1'b0; m_sgb = 1'b0;
        end else begin
            m_ga  = av  && !(ca  &&  m_apri);
            m_gb  = bv  && !(ca  && !m_apri);
            m_sga = sav && !(sca &&  m_spri);
            m_sgb = sbv && !(sca && !m_spri);
        end
        d_ga = acc_ack_a; d_gb = acc_ack_b; d_sga = sys_ack_a; d_sgb = sys_ack_b;
        check_eq("acc_ack_a", {31'd0, d_ga},  {31'd0, m_ga});
        check_eq("acc_ack_b", {31'd0, d_gb},  {31'd0, m_gb});
        check_eq("sys_ack_a", {31'd0, d_sga}, {31'd0, m_sga});
        check_eq("sys_ack_b", {31'd0, d_sgb}, {31'd0, m_sgb});
        if (r) begin
            m_acc = '0; m_sys = '0; m_cnt = 32'd0; m_apri = 1'b0; m_spri = 1'b0;
        end else begin
            if (m_ga) m_acc[ai] = ad;
            if (m_gb) m_acc[bi] = bd;
            if (m_sga && sai != 3'd7) m_sys[sai] = sad;
            if (m_sgb && sbi != 3'd7) m_sys[sbi] = sbd;
            if ((ca || sca) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (ca)  m_apri = !m_apri;
            if (sca) m_spri = !m_spri;
        end
        s.acc = m_acc; s.sys = m_sys; s.cnt = m_cnt;
        exp_q.push_back(s);
        @(negedge clk);
        s = exp_q.pop_front();
        for (int i = 0; i < 16; i++) check_eq($sformatf("acc%0d", i), acc_o[i], s.acc[i]);
        for (int i = 0; i < 7; i++)  check_eq($sformatf("sysreg%0d", i), sys_o[i], s.sys[i]);
        check_eq("sysreg07", sys_o[7], s.cnt);
    endtask

    task automatic acc_step(input logic r,
                            input logic av, input logic [3:0] ai, input logic [31:0] ad,
                            input logic bv, input logic [3:0] bi, input logic [31:0] bd);
        step(r, av, ai, ad, bv, bi, bd, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic sys_step(input logic sav, input logic [2:0] sai, input logic [31:0] sad,
                            input logic sbv, input logic [2:0] sbi, input logic [31:0] sbd);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, sav, sai, sad, sbv, sbi, sbd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        pa, pb, psa, psb;
        logic [3:0]  ra_i, rb_i;
        logic [2:0]  rsa_i, rsb_i;
        logic [31:0] ra_d, rb_d, rsa_d, rsb_d;

        m_acc = '0; m_sys = '0; m_cnt = 32'd0; m_apri = 1'b0; m_spri = 1'b0;
        @(negedge clk);

        // reset with a request present: nothing acked or written
        step(1'b1, 1'b1, 4'd3, 32'h5555, 1'b1, 4'd3, 32'h6666,
             1'b1, 3'd1, 32'h7777, 1'b0, 3'd0, 32'd0);
        check_eq("rst_ack_a", {31'd0, d_ga}, 32'd0);
        acc_step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        check_eq("rst_acc3", acc_o[3], 32'd0);

        // single write
        acc_step(1'b0, 1'b1, 4'd3, 32'h1234, 1'b0, 4'd0, 32'd0);
        check_eq("single_ack", {31'd0, d_ga}, 32'd1);
        check_eq("single_acc3", acc_o[3], 32'h0000_1234);

        // parallel writes to different indices
        acc_step(1'b0, 1'b1, 4'd1, 32'd5, 1'b1, 4'd2, 32'd9);
        check_eq("par_ack_b", {31'd0, d_gb}, 32'd1);
        check_eq("par_acc1", acc_o[1], 32'd5);
        check_eq("par_acc2", acc_o[2], 32'd9);
        check_eq("par_cnt", sys_o[7], 32'd0);

        // conflict: A wins, B held and acked next cycle
        acc_step(1'b0, 1'b1, 4'd4, 32'hA, 1'b1, 4'd4, 32'hB);
        check_eq("conf1_ack_a", {31'd0, d_ga}, 32'd1);
        check_eq("conf1_ack_b", {31'd0, d_gb}, 32'd0);
        check_eq("conf1_cnt", sys_o[7], 32'd1);
        acc_step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hB);
        check_eq("hold_ack_b", {31'd0, d_gb}, 32'd1);
        check_eq("hold_acc4", acc_o[4], 32'hB);
        // second conflict: B wins
        acc_step(1'b0, 1'b1, 4'd4, 32'hC, 1'b1, 4'd4, 32'hD);
        check_eq("conf2_ack_a", {31'd0, d_ga}, 32'd0);
        check_eq("conf2_acc4", acc_o[4], 32'hD);
        acc_step(1'b0, 1'b1, 4'd4, 32'hC, 1'b0, 4'd0, 32'd0);
        check_eq("conf2_hold_acc4", acc_o[4], 32'hC);
        check_eq("conf2_cnt", sys_o[7], 32'd2);

        // sysreg writes, index 7 discarded
        sys_step(1'b1, 3'd7, 32'hDEAD, 1'b1, 3'd0, 32'h0BEE);
        check_eq("sys7_ack", {31'd0, d_sga}, 32'd1);
        check_eq("sys7_keep", sys_o[7], 32'd2);
        check_eq("sys0", sys_o[0], 32'h0BEE);

        // simultaneous acc and sysreg conflicts count once
        step(1'b0, 1'b1, 4'd6, 32'h61, 1'b1, 4'd6, 32'h62,
             1'b1, 3'd2, 32'h21, 1'b1, 3'd2, 32'h22);
        check_eq("dual_cnt", sys_o[7], 32'd3);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h62,
             1'b0, 3'd0, 32'd0, 1'b1, 3'd2, 32'h22);
        check_eq("dual_acc6", acc_o[6], 32'h62);
        check_eq("dual_sys2", sys_o[2], 32'h22);

        // saturation of the conflict counter
        force dut.conf_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.conf_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        acc_step(1'b0, 1'b1, 4'd5, 32'h51, 1'b1, 4'd5, 32'h52);
        check_eq("sat_cnt1", sys_o[7], 32'hFFFF_FFFF);
        acc_step(1'b0, 1'b1, 4'd5, 32'h53, 1'b1, 4'd5, 32'h52);
        check_eq("sat_cnt2", sys_o[7], 32'hFFFF_FFFF);
        acc_step(1'b0, 1'b1, 4'd5, 32'h53, 1'b1, 4'd5, 32'h54);
        check_eq("sat_cnt3", sys_o[7], 32'hFFFF_FFFF);

        // leave acc pointer at B, then reset mid-conflict on acc9
        acc_step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h54);
        acc_step(1'b0, 1'b1, 4'd8, 32'h81, 1'b1, 4'd8, 32'h82);
        acc_step(1'b1, 1'b1, 4'd9, 32'h91, 1'b1, 4'd9, 32'h92);
        check_eq("mrst_ack_a", {31'd0, d_ga}, 32'd0);
        check_eq("mrst_ack_b", {31'd0, d_gb}, 32'd0);
        check_eq("mrst_acc9", acc_o[9], 32'd0);
        acc_step(1'b0, 1'b1, 4'd9, 32'h91, 1'b1, 4'd9, 32'h92);
        check_eq("post_rst_ack_a", {31'd0, d_ga}, 32'd1);
        check_eq("post_rst_ack_b", {31'd0, d_gb}, 32'd0);
        check_eq("post_rst_acc9", acc_o[9], 32'h91);
        acc_step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h92);

        // random traffic; requesters hold until acked
        pa = 1'b0; pb = 1'b0; psa = 1'b0; psb = 1'b0;
        ra_i = 4'd0; rb_i = 4'd0; rsa_i = 3'd0; rsb_i = 3'd0;
        ra_d = 32'd0; rb_d = 32'd0; rsa_d = 32'd0; rsb_d = 32'd0;
        for (int k = 0; k < 200; k++) begin
            if (!pa  && $urandom_range(0, 1) == 1) begin pa  = 1'b1; ra_i  = 4'($urandom_range(0, 3)); ra_d  = $urandom; end
            if (!pb  && $urandom_range(0, 1) == 1) begin pb  = 1'b1; rb_i  = 4'($urandom_range(0, 3)); rb_d  = $urandom; end
            if (!psa && $urandom_range(0, 1) == 1) begin psa = 1'b1; rsa_i = 3'($urandom_range(4, 7)); rsa_d = $urandom; end
            if (!psb && $urandom_range(0, 1) == 1) begin psb = 1'b1; rsb_i = 3'($urandom_range(4, 7)); rsb_d = $urandom; end
            step(1'b0, pa, ra_i, ra_d, pb, rb_i, rb_d, psa, rsa_i, rsa_d, psb, rsb_i, rsb_d);
            if (m_ga)  pa  = 1'b0;
            if (m_gb)  pb  = 1'b0;
            if (m_sga) psa = 1'b0;
            if (m_sgb) psb = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
